in_port_unit: RTL and testbench

- Input-port peripheral for the CPU datapath, the input-side counterpart of the output port.
- An external device presents a 32-bit word on InputDev and raises Strobe. The unit captures the word into a small FIFO and acknowledges it.
- During an "in" instruction the control unit asserts InPortout; the unit then drives the FIFO head onto the bus-mux input and pops it when the read completes.
- Status flags tell the control unit and the device whether data is waiting and whether any was lost.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/in_port_fifo.sv | 55 +++++
 rtl/in_port_unit.sv | 76 +++++++
 tb/tb_in_port_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word width, input-port read FSM states and
// port-select codes used by both the input and output port blocks.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rd_state_t;

  localparam logic [1:0] PORT_SEL_NONE = 2'd0;
  localparam logic [1:0] PORT_SEL_IN   = 2'd1;
  localparam logic [1:0] PORT_SEL_OUT  = 2'd2;

endpackage

// File: rtl/in_port_fifo.sv
// DEPTH-entry synchronous FIFO for the input port. Full/empty come from the
// occupancy counter, so the pointers are free to wrap.
module in_port_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] head,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              pushed
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              popped;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign popped = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pushed = push & (~full | popped);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pushed) wr_ptr <= wr_ptr + 1'b1;
      if (popped) rd_ptr <= rd_ptr + 1'b1;
      case ({pushed, popped})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pushed) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/in_port_unit.sv
// Input-port peripheral: captures strobed device words into a FIFO and
// presents the head on the bus during an "in" read, popping when it ends.
module in_port_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [WORD_W-1:0] InputDev,
  input  logic              Strobe,
  input  logic              InPortout,
  input  logic              ClrStatus,
  output logic [WORD_W-1:0] BusMuxIn_InPort,
  output logic              Ack,
  output logic              Ready,
  output logic              DataValid,
  output logic              Overrun,
  output logic [PTR_W:0]    Count
);

  rd_state_t         state;
  logic              strobe_q;
  logic              strobe_rise;
  logic              pop_req;
  logic              pushed;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] head;

  assign strobe_rise = Strobe & ~strobe_q;
  // Pop on the falling edge of the read window so the bus stays stable throughout.
  assign pop_req     = (state == R_BUSY) & ~InPortout;

  in_port_fifo #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Clear),
    .push  (strobe_rise),
    .pop   (pop_req),
    .din   (InputDev),
    .head  (head),
    .count (Count),
    .full  (full),
    .empty (empty),
    .pushed(pushed)
  );

  assign Ready           = ~full;
  assign DataValid       = ~empty;
  assign BusMuxIn_InPort = (InPortout & DataValid) ? head : '0;

  // Sampled even during Clear so a strobe held through reset is not captured.
  always_ff @(posedge Clock) strobe_q <= Strobe;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state   <= R_IDLE;
      Ack     <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      case (state)
        R_IDLE:  if (InPortout)  state <= R_BUSY;
        R_BUSY:  if (!InPortout) state <= R_IDLE;
        default: state <= R_IDLE;
      endcase
      Ack <= pushed;
      if (strobe_rise && !pushed) Overrun <= 1'b1;
      else if (ClrStatus)         Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in_port_unit.sv
// Directed bench for in_port_unit: a queue-based model of the port is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_in_port_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] InputDev = '0;
  logic        Strobe = 1'b1;
  logic        InPortout = 1'b0;
  logic        ClrStatus = 1'b0;
  logic [31:0] BusMuxIn_InPort;
  logic        Ack, Ready, DataValid, Overrun;
  logic [PTR_W:0] Count;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  in_port_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .Clock(Clock), .Clear(Clear), .InputDev(InputDev), .Strobe(Strobe),
    .InPortout(InPortout), .ClrStatus(ClrStatus),
    .BusMuxIn_InPort(BusMuxIn_InPort), .Ack(Ack), .Ready(Ready),
    .DataValid(DataValid), .Overrun(Overrun), .Count(Count)
  );

  always #5 Clock = ~Clock;

  // Model: stored words as a queue, plus the few bits of history the rules need.
  logic [31:0] m_q[$];
  bit m_ovr, m_ack, m_reading, m_prev_strobe;

  always @(posedge Clock) begin
    bit rise, popnow, accept;
    if (Clear) begin
      m_q.delete();
      m_ovr = 0; m_ack = 0; m_reading = 0;
    end else begin
      rise   = Strobe && !m_prev_strobe;
      popnow = m_reading && !InPortout && m_q.size() > 0;
      accept = rise && (m_q.size() < DEPTH || popnow);
      if (popnow) void'(m_q.pop_front());
      if (accept) m_q.push_back(InputDev);
      m_ack = accept;
      if (rise && !accept) m_ovr = 1;
      else if (ClrStatus)  m_ovr = 0;
      m_reading = InPortout;
    end
    m_prev_strobe = Strobe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      logic [31:0] exp_bus;
      exp_bus = (InPortout && m_q.size() > 0) ? m_q[0] : 32'd0;
      chk("bus", BusMuxIn_InPort, exp_bus);
      chk("count", 32'(Count), 32'(m_q.size()));
      chk("ready", 32'(Ready), 32'(m_q.size() < DEPTH));
      chk("datavalid", 32'(DataValid), 32'(m_q.size() > 0));
      chk("ack", 32'(Ack), 32'(m_ack));
      chk("overrun", 32'(Overrun), 32'(m_ovr));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic strobe_word(input logic [31:0] w);
    InputDev = w; Strobe = 1'b1;
    tick();
    Strobe = 1'b0;
    tick();
  endtask

  // Holds InPortout for n cycles and returns the bus value seen at its start.
  task automatic read_word(input int n, output logic [31:0] w);
    InPortout = 1'b1;
    #1 w = BusMuxIn_InPort;
    repeat (n) tick();
    InPortout = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] w;
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    tick();
    chk_en = 1;
    tick();
    Clear = 1'b0;
    tick(); tick();
    chk("rst_count_held_strobe", 32'(Count), 32'd0);
    chk("rst_ready", 32'(Ready), 32'd1);
    Strobe = 1'b0;
    tick();

    // Single transfer
    InputDev = 32'd10; Strobe = 1'b1;
    tick();
    chk("single_ack", 32'(Ack), 32'd1);
    Strobe = 1'b0;
    tick();
    chk("single_ack_pulse", 32'(Ack), 32'd0);
    read_word(1, w);
    chk("single_data", w, 32'd10);
    chk("single_count_after", 32'(Count), 32'd0);

    // Held strobe, long read
    InputDev = 32'hA5A5_0001; Strobe = 1'b1;
    repeat (5) tick();
    Strobe = 1'b0;
    chk("held_count", 32'(Count), 32'd1);
    tick();
    InPortout = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("long_read_bus", BusMuxIn_InPort, 32'hA5A5_0001);
      tick();
    end
    InPortout = 1'b0;
    tick();
    chk("long_read_popped", 32'(Count), 32'd0);

    // Order and wrap-around
    for (int i = 1; i <= 4; i++) strobe_word(32'(i));
    chk("full_ready", 32'(Ready), 32'd0);
    read_word(1, w); chk("order1", w, 32'd1);
    read_word(2, w); chk("order2", w, 32'd2);
    strobe_word(32'd5);
    strobe_word(32'd6);
    for (int i = 3; i <= 6; i++) begin
      read_word(1, w);
      chk("wrap_order", w, 32'(i));
    end
    chk("wrap_empty", 32'(Count), 32'd0);

    // Overrun
    for (int i = 11; i <= 14; i++) strobe_word(32'(i));
    InputDev = 32'hDEAD; Strobe = 1'b1;
    tick();
    chk("ovr_no_ack", 32'(Ack), 32'd0);
    chk("ovr_set", 32'(Overrun), 32'd1);
    chk("ovr_count", 32'(Count), 32'd4);
    Strobe = 1'b0;
    tick();
    ClrStatus = 1'b1;
    tick();
    ClrStatus = 1'b0;
    chk("ovr_cleared", 32'(Overrun), 32'd0);

    // Simultaneous pop and capture on a full FIFO
    InPortout = 1'b1;
    #1 chk("sim_head", BusMuxIn_InPort, 32'd11);
    tick(); tick();
    InPortout = 1'b0; InputDev = 32'd77; Strobe = 1'b1;
    tick();
    Strobe = 1'b0;
    chk("sim_count", 32'(Count), 32'd4);
    chk("sim_ovr", 32'(Overrun), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      read_word(1, w);
      chk("sim_order", w, (i == 3) ? 32'd77 : 32'(12 + i));
    end

    // Empty read
    read_word(2, w);
    chk("empty_bus", w, 32'd0);
    chk("empty_count", 32'(Count), 32'd0);
    chk("empty_ovr", 32'(Overrun), 32'd0);
    tick();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
